// File: rtl/br_pred_stats.sv
// br_pred_stats: per-channel branch prediction counters with snapshot reads, report strobe and optional sliding window (macro BR_PRED_STATS_WINDOW_EN)
module br_pred_stats #(
  parameter int N_CH = 4,
  parameter int CNT_W = 32,
  parameter int WIN_DEPTH = 16,
  parameter int RPT_PERIOD = 50,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int WIN_W = $clog2(WIN_DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_is_br,
  input  logic             i_is_correct,
  input  logic [CH_W-1:0]  i_ch,
  input  logic             i_clr,
  input  logic             i_rd_req,
  input  logic [CH_W-1:0]  i_rd_ch,
  output logic             o_rd_vld,
  output logic [CNT_W-1:0] o_rd_br,
  output logic [CNT_W-1:0] o_rd_correct,
  output logic [WIN_W-1:0] o_win_correct,
  output logic             o_win_full,
  output logic             o_rpt_pulse,
  output logic             o_sat
);
  localparam int RP_W = (RPT_PERIOD > 1) ? $clog2(RPT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(RPT_PERIOD - 1);
  logic [CNT_W-1:0] br_cnt [N_CH];
  logic [CNT_W-1:0] co_cnt [N_CH];
  logic [RP_W-1:0] rpt_cnt;
  logic acc;
  logic rd_ok;
  logic any_max;
  assign acc = i_is_br && !i_clr && (32'(i_ch) < N_CH);
  assign rd_ok = 32'(i_rd_ch) < N_CH;
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // saturating branch and correct counters for one channel; clear wins over a same-cycle branch
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        br_cnt[g] <= '0;
        co_cnt[g] <= '0;
      end else if (i_clr) begin
        br_cnt[g] <= '0;
        co_cnt[g] <= '0;
      end else if (acc && i_ch == CH_W'(g)) begin
        if (br_cnt[g] != MAX) br_cnt[g] <= br_cnt[g] + 1'b1;
        if (i_is_correct && co_cnt[g] != MAX) co_cnt[g] <= co_cnt[g] + 1'b1;
      end
  end
  // detect any counter sitting at its ceiling
  always_comb begin
    any_max = 1'b0;
    for (int k = 0; k < N_CH; k++) any_max = any_max | (br_cnt[k] == MAX) | (co_cnt[k] == MAX);
  end
  // sticky saturation flag
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_sat <= 1'b0;
    else o_sat <= i_clr ? 1'b0 : (o_sat | any_max);
  // one-cycle snapshot read of pre-update counter values; data holds between reads
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_rd_vld <= 1'b0;
      o_rd_br <= '0;
      o_rd_correct <= '0;
    end else begin
      o_rd_vld <= i_rd_req;
      if (i_rd_req) begin
        o_rd_br <= rd_ok ? br_cnt[i_rd_ch] : '0;
        o_rd_correct <= rd_ok ? co_cnt[i_rd_ch] : '0;
      end
    end
  // modulo report counter; the pulse follows the branch that wraps it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rpt_cnt <= '0;
      o_rpt_pulse <= 1'b0;
    end else if (i_clr) begin
      rpt_cnt <= '0;
      o_rpt_pulse <= 1'b0;
    end else begin
      o_rpt_pulse <= acc && rpt_cnt == RP_LAST;
      if (acc) rpt_cnt <= (rpt_cnt == RP_LAST) ? '0 : rpt_cnt + 1'b1;
    end
`ifdef BR_PRED_STATS_WINDOW_EN
  logic [WIN_DEPTH-1:0] hist;
  logic [WIN_W-1:0] fill;
  // shift accepted outcomes into the history, retiring the oldest once full, and track the correct count
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      hist <= '0;
      fill <= '0;
      o_win_full <= 1'b0;
      o_win_correct <= '0;
    end else if (i_clr) begin
      hist <= '0;
      fill <= '0;
      o_win_full <= 1'b0;
      o_win_correct <= '0;
    end else if (acc) begin
      hist <= {hist[WIN_DEPTH-2:0], i_is_correct};
      fill <= o_win_full ? fill : fill + 1'b1;
      o_win_full <= o_win_full | (fill == WIN_W'(WIN_DEPTH - 1));
      o_win_correct <= o_win_correct + WIN_W'(i_is_correct) - WIN_W'(o_win_full & hist[WIN_DEPTH-1]);
    end
`else
  assign o_win_correct = '0;
  assign o_win_full = 1'b0;
`endif
endmodule

// File: tb/tb_br_pred_stats.sv
// tb_br_pred_stats: directed scoreboard bench for br_pred_stats (32-bit and 4-bit counter instances share stimulus)
module tb_br_pred_stats;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b1;
  logic i_is_br = 1'b0;
  logic i_is_correct = 1'b0;
  logic [1:0] i_ch = '0;
  logic i_clr = 1'b0;
  logic i_rd_req = 1'b0;
  logic [1:0] i_rd_ch = '0;
  logic o_rd_vld, o_win_full, o_rpt_pulse, o_sat;
  logic [31:0] o_rd_br, o_rd_correct;
  logic [4:0] o_win_correct;
  logic s_rd_vld, s_win_full, s_rpt_pulse, s_sat;
  logic [3:0] s_rd_br, s_rd_correct;
  logic [4:0] s_win_correct;
  int ncmp = 0;
  int nerr = 0;
  int unsigned mb [3];
  int unsigned mc [3];
  int unsigned qb [$];
  int unsigned qc [$];
  bit wq [$];
  int rc = 0;
  bit exp_pulse = 0;
  logic req_d;
  int np;

  br_pred_stats #(.N_CH(3), .CNT_W(32), .WIN_DEPTH(16), .RPT_PERIOD(50)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_is_br(i_is_br), .i_is_correct(i_is_correct), .i_ch(i_ch),
    .i_clr(i_clr), .i_rd_req(i_rd_req), .i_rd_ch(i_rd_ch), .o_rd_vld(o_rd_vld), .o_rd_br(o_rd_br),
    .o_rd_correct(o_rd_correct), .o_win_correct(o_win_correct), .o_win_full(o_win_full),
    .o_rpt_pulse(o_rpt_pulse), .o_sat(o_sat));

  br_pred_stats #(.N_CH(3), .CNT_W(4), .WIN_DEPTH(16), .RPT_PERIOD(50)) u_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_is_br(i_is_br), .i_is_correct(i_is_correct), .i_ch(i_ch),
    .i_clr(i_clr), .i_rd_req(i_rd_req), .i_rd_ch(i_rd_ch), .o_rd_vld(s_rd_vld), .o_rd_br(s_rd_br),
    .o_rd_correct(s_rd_correct), .o_win_correct(s_win_correct), .o_win_full(s_win_full),
    .o_rpt_pulse(s_rpt_pulse), .o_sat(s_sat));

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_rd_vld", o_rd_vld, 0);
    chk("rst_rd_br", o_rd_br, 0);
    chk("rst_rd_correct", o_rd_correct, 0);
    chk("rst_win_correct", o_win_correct, 0);
    chk("rst_win_full", o_win_full, 0);
    chk("rst_rpt_pulse", o_rpt_pulse, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_s_rd_vld", s_rd_vld, 0);
    chk("rst_s_rd_br", s_rd_br, 0);
    chk("rst_s_rd_correct", s_rd_correct, 0);
    chk("rst_s_sat", s_sat, 0);
    chk("rst_s_rpt_pulse", s_rpt_pulse, 0);
  endtask

  task automatic model_clear();
    foreach (mb[k]) begin
      mb[k] = 0;
      mc[k] = 0;
    end
    rc = 0;
    wq.delete();
  endtask

  task automatic step(input bit br = 0, input bit cor = 0, input int ch = 0,
                      input bit clr = 0, input bit rd = 0, input int rch = 0);
    bit acc;
    int ws;
    i_is_br = br;
    i_is_correct = cor;
    i_ch = ch[1:0];
    i_clr = clr;
    i_rd_req = rd;
    i_rd_ch = rch[1:0];
    if (rd) begin
      qb.push_back(rch < 3 ? mb[rch] : 0);
      qc.push_back(rch < 3 ? mc[rch] : 0);
    end
    acc = br && !clr && ch < 3;
    exp_pulse = acc && rc == 49;
    if (clr) model_clear();
    else if (acc) begin
      mb[ch]++;
      if (cor) mc[ch]++;
      rc = (rc + 1) % 50;
      wq.push_back(cor);
      if (wq.size() > 16) void'(wq.pop_front());
    end
    @(posedge i_clk);
    #1;
    i_is_br = 0;
    i_is_correct = 0;
    i_clr = 0;
    i_rd_req = 0;
    chk("rpt_pulse", o_rpt_pulse, exp_pulse);
    ws = 0;
    foreach (wq[k]) ws += wq[k];
`ifdef BR_PRED_STATS_WINDOW_EN
    chk("win_correct", o_win_correct, ws);
    chk("win_full", o_win_full, wq.size() == 16);
`else
    chk("win_correct", o_win_correct, 0);
    chk("win_full", o_win_full, 0);
`endif
  endtask

  always @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) req_d <= 1'b0;
    else req_d <= i_rd_req;

  always @(negedge i_clk) begin
    chk("rd_vld", o_rd_vld, req_d);
    chk("s_rd_vld", s_rd_vld, req_d);
    if (req_d) begin
      if (qb.size() == 0) chk("rd_queue_empty", 1, 0);
      else begin
        int unsigned eb, ec;
        eb = qb.pop_front();
        ec = qc.pop_front();
        chk("rd_br", o_rd_br, eb);
        chk("rd_correct", o_rd_correct, ec);
        chk("s_rd_br", s_rd_br, eb > 15 ? 15 : eb);
        chk("s_rd_correct", s_rd_correct, ec > 15 ? 15 : ec);
      end
    end
  end

  initial begin
    model_clear();
    #1 i_rst_n = 0;
    #20;
    chk_zero();
    @(negedge i_clk) i_rst_n = 1;
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 7; i++) step(.br(1), .cor(i < 5), .ch(2));
    step(.rd(1), .rch(2));
    step(.rd(1), .rch(0));
    step(.rd(1), .rch(3));
    step(.rd(1), .rch(2));
    step();
    step();
    chk("rd_hold_br", o_rd_br, 7);
    chk("rd_hold_correct", o_rd_correct, 5);
    step(.clr(1));
    np = 0;
    for (int i = 0; i < 100; i++) begin
      step(.br(1), .cor(i % 2 == 0), .ch(i % 3));
      if (o_rpt_pulse) np++;
    end
    chk("pulse_total", np, 2);
    step(.rd(1), .rch(0));
    step(.rd(1), .rch(1));
    for (int i = 0; i < 49; i++) step(.br(1), .cor(1), .ch(i % 3));
    step(.clr(1));
    step(.br(1), .cor(1), .ch(1));
    step();
    step();
    step(.clr(1));
    for (int i = 0; i < 17; i++) step(.br(1), .cor(1), .ch(1));
    step();
    step();
    chk("s_sat_set", s_sat, 1);
    chk("sat_wide", o_sat, 0);
    step(.rd(1), .rch(1));
    step(.clr(1));
    step();
    chk("s_sat_clr", s_sat, 0);
    step(.rd(1), .rch(1));
    step();
    step(.clr(1));
    for (int i = 0; i < 16; i++) step(.br(1), .cor(1), .ch(0));
    for (int i = 0; i < 4; i++) step(.br(1), .cor(0), .ch(0));
    step(.br(1), .cor(1), .ch(3));
`ifdef BR_PRED_STATS_WINDOW_EN
    chk("win_full_20", o_win_full, 1);
    chk("win_correct_20", o_win_correct, 12);
`endif
    step(.rd(1), .rch(0));
    step(.clr(1));
    for (int i = 0; i < 3; i++) step(.br(1), .cor(1), .ch(2));
    step(.br(1), .cor(1), .ch(2), .clr(1), .rd(1), .rch(2));
    step(.rd(1), .rch(2));
    step();
    i_rd_req = 1;
    i_rd_ch = 2'd2;
    @(posedge i_clk);
    #1;
    i_rd_req = 0;
    chk("vld_before_rst", o_rd_vld, 1);
    i_rst_n = 0;
    qb.delete();
    qc.delete();
    model_clear();
    #1;
    chk_zero();
    @(negedge i_clk) i_rst_n = 1;
    @(posedge i_clk);
    #1;
    step(.rd(1), .rch(2));
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
